idex_stage: RTL

//  ID/EX pipeline register with integrated load-use hazard detection, for the 5-stage pipelined CPU.

---
 rtl/idex_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating
// count of the load-use bubbles it has inserted.
module idex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    input  logic              id_alusrc,
    input  logic              id_regdst,
    input  logic [3:0]        id_aluop,
    output logic              stall,
    output logic              IDEX_Valid,
    output logic [4:0]        IDEX_Rs,
    output logic [4:0]        IDEX_Rt,
    output logic [4:0]        IDEX_Dst,
    output logic [DATA_W-1:0] IDEX_RsData,
    output logic [DATA_W-1:0] IDEX_RtData,
    output logic [DATA_W-1:0] IDEX_Imm,
    output logic              IDEX_RegWrite,
    output logic              IDEX_MemRead,
    output logic              IDEX_MemWrite,
    output logic              IDEX_MemToReg,
    output logic              IDEX_AluSrc,
    output logic [3:0]        IDEX_AluOp,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic       hazard;
    logic       rs_match;
    logic       rt_match;
    logic [4:0] dst_sel;

    // A load in EX whose (non-zero) destination is read by the instruction in ID.
    always_comb begin
        rs_match = (IDEX_Rt == id_rs);
        rt_match = id_uses_rt && (IDEX_Rt == id_rt);
        hazard   = IDEX_Valid && IDEX_MemRead && (IDEX_Rt != 5'd0) && id_valid
                   && (rs_match || rt_match);
        stall    = hazard && !flush && !hold;
        dst_sel  = id_regdst ? id_rd : id_rt;
    end

    // Pipeline register: hold freezes, flush or hazard loads a bubble, else capture ID.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IDEX_Valid    <= 1'b0;
            IDEX_Rs       <= '0;
            IDEX_Rt       <= '0;
            IDEX_Dst      <= '0;
            IDEX_RsData   <= '0;
            IDEX_RtData   <= '0;
            IDEX_Imm      <= '0;
            IDEX_RegWrite <= 1'b0;
            IDEX_MemRead  <= 1'b0;
            IDEX_MemWrite <= 1'b0;
            IDEX_MemToReg <= 1'b0;
            IDEX_AluSrc   <= 1'b0;
            IDEX_AluOp    <= '0;
        end else if (!hold) begin
            if (flush || hazard) begin
                IDEX_Valid    <= 1'b0;
                IDEX_Rs       <= '0;
                IDEX_Rt       <= '0;
                IDEX_Dst      <= '0;
                IDEX_RsData   <= '0;
                IDEX_RtData   <= '0;
                IDEX_Imm      <= '0;
                IDEX_RegWrite <= 1'b0;
                IDEX_MemRead  <= 1'b0;
                IDEX_MemWrite <= 1'b0;
                IDEX_MemToReg <= 1'b0;
                IDEX_AluSrc   <= 1'b0;
                IDEX_AluOp    <= '0;
            end else begin
                IDEX_Valid    <= id_valid;
                IDEX_Rs       <= id_rs;
                IDEX_Rt       <= id_rt;
                IDEX_Dst      <= dst_sel;
                IDEX_RsData   <= id_rs_data;
                IDEX_RtData   <= id_rt_data;
                IDEX_Imm      <= id_imm;
                IDEX_RegWrite <= id_regwrite && id_valid;
                IDEX_MemRead  <= id_memread  && id_valid;
                IDEX_MemWrite <= id_memwrite && id_valid;
                IDEX_MemToReg <= id_memtoreg && id_valid;
                IDEX_AluSrc   <= id_alusrc   && id_valid;
                IDEX_AluOp    <= id_aluop;
            end
        end
    end

    // Count load-use bubbles only; a flush that coincides with a hazard is not a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!hold && !flush && hazard && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
